// File: rtl/scan_pkg.sv
// Shared types and constants for the scan select generator and its slot helper.
package scan_pkg;

    localparam int unsigned SLOT_N = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SLOT_N-1:0] ALL_SLOTS = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/scan_next_slot.sv
// Slot sequencing helper: from the current slot and the slot mask, finds the
// next enabled slot (cyclic), the first enabled slot, and whether cur is the pass end.
module scan_next_slot
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic [SLOT_N-1:0] mask,
    output logic [SEL_W-1:0]  nxt,
    output logic [SEL_W-1:0]  first,
    output logic              is_last,
    output logic              none_set
);

    // Descending scans leave the lowest qualifying index as the winner.
    always_comb begin
        first   = '0;
        nxt     = '0;
        is_last = 1'b1;
        for (int i = SLOT_N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = SEL_W'(i);
            end
        end
        nxt = first;
        for (int i = SLOT_N - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt     = SEL_W'(i);
                is_last = 1'b0;
            end
        end
    end

    assign none_set = (mask == '0);

endmodule

// File: rtl/scan_sel_gen.sv
// Steps a 2-bit decoder select through slots with a programmable dwell per slot.
// Optional build macro SCAN_MASK_EN adds a per-slot enable mask port.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
    input  logic [SLOT_N-1:0]  mask,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic               sel_en,
    output logic               slot_done,
    output logic               pass_done,
    output logic               busy
);

    state_t             state;
    state_t             next_state;
    logic [DWELL_W-1:0] cnt;
    logic               single_q;
    logic               stop_pend;
    logic [SLOT_N-1:0]  slot_mask;
    logic [SEL_W-1:0]   nxt;
    logic [SEL_W-1:0]   first;
    logic               is_last;
    logic               none_set;
    logic               go;
    logic               end_scan;

`ifdef SCAN_MASK_EN
    assign slot_mask = mask;
`else
    assign slot_mask = ALL_SLOTS;
`endif

    scan_next_slot u_next (
        .cur      (sel),
        .mask     (slot_mask),
        .nxt      (nxt),
        .first    (first),
        .is_last  (is_last),
        .none_set (none_set)
    );

    // A stop seen in the final slot cycle ends the scan as if it were already pending.
    assign go       = (state == IDLE) && start && !stop && !none_set;
    assign end_scan = slot_done && (stop || stop_pend || none_set || (single_q && is_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (go)       next_state = RUN;
            RUN:     if (end_scan) next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        sel_en    = 1'b0;
        slot_done = 1'b0;
        pass_done = 1'b0;
        if (state == RUN) begin
            busy      = 1'b1;
            sel_en    = 1'b1;
            slot_done = (cnt == '0);
            pass_done = (cnt == '0) && is_last;
        end
    end

    // Slot index, dwell counter and sampled controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= '0;
            cnt       <= '0;
            single_q  <= 1'b0;
            stop_pend <= 1'b0;
        end else if (state == IDLE) begin
            stop_pend <= 1'b0;
            if (go) begin
                sel      <= first;
                cnt      <= dwell;
                single_q <= single;
            end else begin
                sel <= '0;
                cnt <= '0;
            end
        end else if (slot_done) begin
            if (end_scan) begin
                sel       <= '0;
                cnt       <= '0;
                stop_pend <= 1'b0;
            end else begin
                sel <= nxt;
                cnt <= dwell;
            end
        end else begin
            cnt <= cnt - DWELL_W'(1);
            if (stop) begin
                stop_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: directed scenarios plus randomized scans
// checked against an arithmetic slot schedule.
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       single;
    logic [7:0] dwell;
`ifdef SCAN_MASK_EN
    logic [3:0] mask;
`endif
    logic [1:0] sel;
    logic       sel_en;
    logic       slot_done;
    logic       pass_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_sel_gen #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .single    (single),
        .dwell     (dwell),
`ifdef SCAN_MASK_EN
        .mask      (mask),
`endif
        .sel       (sel),
        .sel_en    (sel_en),
        .slot_done (slot_done),
        .pass_done (pass_done),
        .busy      (busy)
    );

    // Expected trace: cycle t (1 = first cycle after the start edge) belongs to slot
    // index (t-1)/(d+1) of the repeating enabled-slot list; scan ends at cycle e.
    task automatic run_scan(input int d, input bit sgl, input int stop_at, input logic [3:0] msk);
        int         slots[$];
        int         n;
        int         per;
        int         e;
        int         j;
        logic [5:0] exp_v;
        logic [5:0] got_v;
        for (int i = 0; i < 4; i++) if (msk[i]) slots.push_back(i);
        n   = slots.size();
        per = d + 1;
        e   = sgl ? n * per : 1 << 30;
        if (stop_at > 0 && ((stop_at + per - 1) / per) * per < e) e = ((stop_at + per - 1) / per) * per;
        @(negedge clk);
        dwell  = 8'(d);
        single = sgl;
        start  = 1'b1;
        stop   = 1'b0;
`ifdef SCAN_MASK_EN
        mask   = msk;
`endif
        @(posedge clk);
        for (int t = 1; t <= e + 2; t++) begin
            @(negedge clk);
            if (t <= e) begin
                j     = (t - 1) / per;
                exp_v = {1'b1, 1'b1, 2'(slots[j % n]), (t % per) == 0, ((t % per) == 0) && ((j % n) == n - 1)};
            end else begin
                exp_v = '0;
            end
            got_v = {busy, sel_en, sel, slot_done, pass_done};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL scan t=%0d d=%0d single=%0b stop_at=%0d mask=%b: got busy,en,sel,sd,pd=%b expected %b",
                         t, d, sgl, stop_at, msk, got_v, exp_v);
            end
            start = (t <= e) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop  = (t == stop_at);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        single = 1'b0;
        dwell  = '0;
`ifdef SCAN_MASK_EN
        mask   = 4'b1111;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, sel_en, sel, slot_done, pass_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 000000", {busy, sel_en, sel, slot_done, pass_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, sel_en, sel, slot_done, pass_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: got %b expected 000000", {busy, sel_en, sel, slot_done, pass_done});
        end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        dwell  = 8'd7;
        single = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if ({busy, sel} !== 3'b101) begin
            errors++;
            $display("FAIL mid_scan_slot1: got busy,sel=%b expected 101", {busy, sel});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sel_en, sel, slot_done, pass_done} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 000000", {busy, sel_en, sel, slot_done, pass_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({busy, sel, slot_done} !== {t <= 8, 2'b00, t == 8}) begin
                errors++;
                $display("FAIL restart t=%0d: got busy,sel,sd=%b expected %b", t, {busy, sel, slot_done},
                         {t <= 8, 2'b00, t == 8});
            end
            stop = (t == 8);
        end
        stop = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL start_with_stop t=%0d: got busy=%b expected 0", t, busy);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_dwell_change();
        logic [3:0] exp_v;
        @(negedge clk);
        dwell  = 8'd1;
        single = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t <= 2)      exp_v = {1'b1, 2'd0, t == 2};
            else if (t <= 6) exp_v = {1'b1, 2'd1, t == 6};
            else             exp_v = 4'b0;
            checks++;
            if ({busy, sel, slot_done} !== exp_v) begin
                errors++;
                $display("FAIL dwell_change t=%0d: got busy,sel,sd=%b expected %b", t, {busy, sel, slot_done}, exp_v);
            end
            if (t == 1) dwell = 8'd3;
            stop = (t == 3);
        end
        stop = 1'b0;
    endtask

`ifdef SCAN_MASK_EN
    task automatic test_mask_zero();
        @(negedge clk);
        mask  = 4'b0000;
        start = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL mask_zero t=%0d: got busy=%b expected 0", t, busy);
            end
        end
        start = 1'b0;
        mask  = 4'b1111;
    endtask
`endif

    task automatic test_directed_scans();
        run_scan(2, 1'b1, 0, 4'b1111);
        run_scan(0, 1'b0, 6, 4'b1111);
        run_scan(5, 1'b0, 15, 4'b1111);
        run_scan(0, 1'b1, 0, 4'b1111);
`ifdef SCAN_MASK_EN
        run_scan(1, 1'b1, 0, 4'b1010);
        run_scan(0, 1'b0, 5, 4'b0100);
`endif
    endtask

    task automatic test_random_scans();
        int         d;
        bit         sgl;
        int         stop_at;
        int         n;
        logic [3:0] msk;
        for (int k = 0; k < 24; k++) begin
            d   = int'($urandom_range(0, 5));
            sgl = 1'($urandom_range(0, 1));
`ifdef SCAN_MASK_EN
            msk = 4'($urandom_range(1, 15));
`else
            msk = 4'b1111;
`endif
            n = $countones(msk);
            if (sgl) stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * (d + 1))) : 0;
            else     stop_at = int'($urandom_range(1, 3 * n * (d + 1)));
            run_scan(d, sgl, stop_at, msk);
        end
    endtask

    initial begin
        test_reset();
        test_directed_scans();
        test_start_stop_idle();
        test_dwell_change();
        test_reset_mid_scan();
`ifdef SCAN_MASK_EN
        test_mask_zero();
`endif
        test_random_scans();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
